// File: rtl/regfile_bram_mt_if.sv
// Port bundle for the multi-thread register file: write sources, write/read
// control, clear-engine control and status.
// master = CPU-side driver, slave = register file.
interface regfile_bram_mt_if #(
  parameter int WIDTH     = 16,
  parameter int N_THREADS = 16,
  parameter int N_REGS    = 16,
  parameter int N_SRC     = 4
);
  // MSB(N-1) for N >= 2 equals $clog2(N)-1.
  localparam int TMSB = $clog2(N_THREADS) - 1;
  localparam int AMSB = $clog2(N_REGS) - 1;
  localparam int SMSB = $clog2(N_SRC) - 1;

  logic [N_SRC*WIDTH-1:0] din_flat;
  logic [SMSB:0]          din_select;
  logic                   wr_en;
  logic [TMSB:0]          wr_thread_num;
  logic [AMSB:0]          wr_addr;
  logic                   rd_en0;
  logic [TMSB:0]          rd_thread_num;
  logic [AMSB:0]          rd_addr;
  logic                   rd_en1;
  logic [WIDTH-1:0]       dout;
  logic                   clr_start;
  logic [TMSB:0]          clr_thread_num;
  logic                   clr_busy;
  logic                   clr_done;

  modport master (
    output din_flat, din_select, wr_en, wr_thread_num, wr_addr,
    output rd_en0, rd_thread_num, rd_addr, rd_en1,
    output clr_start, clr_thread_num,
    input  dout, clr_busy, clr_done
  );

  modport slave (
    input  din_flat, din_select, wr_en, wr_thread_num, wr_addr,
    input  rd_en0, rd_thread_num, rd_addr, rd_en1,
    input  clr_start, clr_thread_num,
    output dout, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_bram_mt.sv
// Multi-thread register file in block RAM with same-cycle write forwarding
// and a background per-thread clear engine.
// Latency: write visible to a read in the same cycle; read rd_en0@t, rd_en1@t+1 -> dout@t+2.
// Backpressure: none; an external write steals the write port from the clear engine for that cycle.
// Ports: CLK, rst_n (async active-low); bus (slave modport) carries din_flat/din_select,
//        wr_en/wr_thread_num/wr_addr, rd_en0/rd_thread_num/rd_addr, rd_en1, dout,
//        clr_start/clr_thread_num, clr_busy, clr_done.
module regfile_bram_mt #(
  parameter int WIDTH     = 16,
  parameter int N_THREADS = 16,
  parameter int N_REGS    = 16,
  parameter int N_SRC     = 4
) (
  input  logic              CLK,
  input  logic              rst_n,
  regfile_bram_mt_if.slave  bus
);
  localparam int TMSB  = $clog2(N_THREADS) - 1;
  localparam int AMSB  = $clog2(N_REGS) - 1;
  localparam int AW    = TMSB + AMSB + 2;
  localparam int DEPTH = N_THREADS * N_REGS;
  localparam logic [AMSB:0] LAST_REG = (AMSB + 1)'(N_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state;
  logic [TMSB:0]  clr_thread;
  logic [AMSB:0]  clr_cnt;
  logic           clr_busy_q;
  logic           clr_done_q;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_r;
  logic [WIDTH-1:0] dout_q;

  logic [WIDTH-1:0] src_dat;
  logic             clr_wr;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdat;
  logic [AW-1:0]    mem_raddr;
  logic             fwd;

  // Source mux; any select value without a matching source falls back to
  // source 0 (thread memory).
  always_comb begin
    src_dat = bus.din_flat[WIDTH-1:0];
    for (int k = 1; k < N_SRC; k++) begin
      if (int'(bus.din_select) == k) begin
        src_dat = bus.din_flat[k*WIDTH +: WIDTH];
      end
    end
  end

  // Single write port: the external write always wins, the clear engine
  // only uses otherwise idle cycles.
  always_comb begin
    clr_wr    = (state == CLEAR) && !bus.wr_en;
    mem_we    = bus.wr_en || clr_wr;
    mem_waddr = bus.wr_en ? {bus.wr_thread_num, bus.wr_addr} : {clr_thread, clr_cnt};
    mem_wdat  = bus.wr_en ? src_dat : '0;
    mem_raddr = {bus.rd_thread_num, bus.rd_addr};
    fwd       = mem_we && (mem_waddr == mem_raddr);
  end

  // Storage has no reset so it maps onto block RAM; a clear interrupted by
  // reset leaves already-zeroed words zero.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  // Stage 0 captures the BRAM word, or the word being written this cycle so
  // a read always sees writes of the same cycle. Stage 1 is a fabric register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_r   <= '0;
      dout_q <= '0;
    end else begin
      if (bus.rd_en0) begin
        rd_r <= fwd ? mem_wdat : mem[mem_raddr];
      end
      if (bus.rd_en1) begin
        dout_q <= rd_r;
      end
    end
  end

  // Clear engine. clr_start while busy is ignored; in the clr_done cycle the
  // FSM is already IDLE, so a back-to-back start is accepted.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clr_thread <= '0;
      clr_cnt    <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            state      <= CLEAR;
            clr_thread <= bus.clr_thread_num;
            clr_cnt    <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          // A cycle with an external write is a stall: nothing advances.
          if (!bus.wr_en) begin
            if (clr_cnt == LAST_REG) begin
              state      <= IDLE;
              clr_cnt    <= '0;
              clr_busy_q <= 1'b0;
              clr_done_q <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout     = dout_q;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
endmodule
